// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared state and order encodings for stream_unpacker
package stream_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic ORDER_LR = 1'b0;
    localparam logic ORDER_RL = 1'b1;

endpackage

// File: rtl/stream_unpacker.sv
// rtl/stream_unpacker.sv - word to slice unpacker; STREAM_UNPACKER_LAST_EN adds out_last
module stream_unpacker
    import stream_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int SLICE_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               order_i,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] out_data
`ifdef STREAM_UNPACKER_LAST_EN
    ,
    output logic               out_last
`endif
);

    localparam int N   = WORD_W / SLICE_W;
    localparam int K_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [K_W-1:0] LAST = K_W'(N - 1);

    if ((WORD_W % SLICE_W) != 0) begin : g_bad_width
        $fatal(1, "stream_unpacker: WORD_W must be a multiple of SLICE_W");
    end

    state_t              state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                order_q, order_d;
    logic                in_fire;
    logic                out_fire;

    // The current slice always sits at the end the word is being consumed from,
    // so out_data is a pure select of registered state.
    assign out_valid = (state_q == SHIFT);
    assign out_data  = (order_q == ORDER_RL) ? data_q[SLICE_W-1:0]
                                             : data_q[WORD_W-1 -: SLICE_W];
`ifdef STREAM_UNPACKER_LAST_EN
    assign out_last  = out_valid && (k_q == LAST);
`endif

    // Next-state: accept, shift per handshake, chain a new word on the final slice.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        data_d   = data_q;
        order_d  = order_q;
        in_ready = (state_q == IDLE) || ((k_q == LAST) && out_ready);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = SHIFT;
                    k_d     = '0;
                    data_d  = in_data;
                    order_d = order_i;
                end
            end
            SHIFT: begin
                if (out_fire) begin
                    if (k_q == LAST) begin
                        k_d = '0;
                        if (in_fire) begin
                            data_d  = in_data;
                            order_d = order_i;
                        end else begin
                            state_d = IDLE;
                            data_d  = '0;
                        end
                    end else begin
                        k_d    = k_q + K_W'(1);
                        data_d = (order_q == ORDER_RL) ? (data_q >> SLICE_W)
                                                       : (data_q << SLICE_W);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
                data_d  = '0;
            end
        endcase
    end

    // State register; reset drops any partially emitted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            data_q  <= '0;
            order_q <= ORDER_LR;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            data_q  <= data_d;
            order_q <= order_d;
        end
    end

endmodule

// File: doc/stream_unpacker.md
STREAM_UNPACKER -- requirements
Module: stream_unpacker

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning the input word width in bits.
REQ-002 SHALL have parameter SLICE_W, default 8, meaning the output slice width in bits; WORD_W % SLICE_W == 0 is checked at elaboration and a violation is a fatal error.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port order_i, input, 1: 0 = left-to-right (MSB slice first, ">>"); 1 = right-to-left (LSB slice first, "<< SLICE_W").
REQ-006 SHALL have port in_valid, input, 1, word offered.
REQ-007 SHALL have port in_ready, output, 1, word accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data, input, WORD_W, word to unpack.
REQ-009 SHALL have port out_valid, output, 1, slice available.
REQ-010 SHALL have port out_ready, input, 1, slice consumed when out_valid && out_ready.
REQ-011 SHALL have port out_data, output, SLICE_W, current slice.
REQ-012 SHALL have port out_last, output, 1, present only under STREAM_UNPACKER_LAST_EN; marks the final slice of a word.

Function
REQ-013 SHALL emit N = WORD_W/SLICE_W slices per accepted word, in the order selected by order_i.
REQ-014 SHALL sample order_i only at word acceptance; changes mid-word SHALL have no effect on that word.
REQ-015 SHALL implement states IDLE (no word held) and SHIFT (word held, slice count k in 0..N-1).
REQ-016 SHALL move IDLE->SHIFT on acceptance, with out_valid=1 and the first slice on out_data in the next cycle (latency 1).
REQ-017 SHALL, in SHIFT, advance to the next slice on each out handshake while k < N-1.
REQ-018 SHALL, on the handshake of slice N-1, go to IDLE; if a new word is accepted in that same cycle, it SHALL go to SHIFT with k=0 and the new word's first slice next cycle (no bubble).
REQ-019 SHALL drive in_ready = (state==IDLE) || (k==N-1 && out_ready); this combinational out_ready->in_ready path is intentional.
REQ-020 SHALL hold out_data, out_valid, and out_last stable while out_valid && !out_ready.
REQ-021 SHALL register out_data: a held shift register shifting by SLICE_W per handshake, with no combinational path from in_data.
REQ-022 SHALL, when N==1, emit the word unchanged regardless of order_i, with out_last=1 on every slice.
REQ-023 SHALL make the concatenation of emitted slices (first = MSB) equal in_data for order_i=0, and equal {<<SLICE_W{in_data}} for order_i=1.

Reset
REQ-024 SHALL, on rst_n low at any time, force: state=IDLE, k=0, out_valid=0, out_data=0, out_last=0, in_ready=1 (after reset deassertion).
REQ-025 SHALL discard a partially emitted word on reset mid-operation; no residual slice SHALL appear after release.

Configuration
REQ-026 SHALL, with STREAM_UNPACKER_LAST_EN defined, provide out_last = (k==N-1) && out_valid; without it, the port and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 SHALL place the state enum (IDLE, SHIFT) and the order encoding constants (ORDER_LR=0, ORDER_RL=1) in shared package stream_pkg.
REQ-028 SHALL be a single module with no sub-modules; the slice counter is inline.

Verification
REQ-029 SHALL cover: order_i=0, in_data=32'h172A7FFF, out_ready=1 -> out_data 17,2A,7F,FF on consecutive cycles, out_last on FF.
REQ-030 SHALL cover: order_i=1, same word -> FF,7F,2A,17; concatenation equals 32'hFF7F2A17.
REQ-031 SHALL cover: two words back-to-back, out_ready=1 -> 8 slices in 8 consecutive cycles, in_ready high at the cycle of slice 3.
REQ-032 SHALL cover: out_ready low for 3 cycles on slice 2 -> out_data=7F held stable, in_ready=0 throughout.
REQ-033 SHALL cover: order_i toggled during slice 1 -> the word's order is unchanged; the next word uses the new order.
REQ-034 SHALL cover: rst_n pulsed after slice 1 -> out_valid=0 within the reset; after release, in_ready=1 and no further slices of the old word appear.
